store_trace_recorder: RTL and testbench

Captures the store stream of the single-cycle `mips` core (every cycle with `memwrite` high) into a record FIFO of {cycle, address, data}, and presents it on a valid/ready stream. The stream is the producer side of the golden `.run` store trace that the CPU bench consumes. Capture and the cycle count stop when `pc` reaches the program end address, and `done` flags a fully drained trace. It sits beside `mips`/`dmem`, tapping the same `memwrite`/`aluout`/`writedata`/`pc` nets.

---
 rtl/trace_pkg.sv | 15 +
 rtl/trace_fifo.sv | 51 +++++
 rtl/store_trace_recorder.sv | 83 ++++++++
 tb/tb_store_trace_recorder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and defaults for the store trace recorder: the record layout
// captured from the CPU store stream and the "no program end" PC marker.
package trace_pkg;

    localparam int          TRACE_DEPTH = 16;
    localparam int          TRACE_CYCW  = 32;
    localparam logic [31:0] PC_NO_END   = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [TRACE_CYCW-1:0] cycle;
        logic [31:0]           addr;
        logic [31:0]           data;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through record FIFO; the head entry is visible whenever the
// FIFO is non-empty, and a push into a full FIFO is accepted only alongside a pop.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  trace_rec_t wr_rec,
    output trace_rec_t rd_rec,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB separates full from empty when the low bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_rec  = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of always_ff evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; entries are only observable
    // between the pointers, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_rec;
    end

endmodule

// File: rtl/store_trace_recorder.sv
// Taps the mips store stream (memwrite/aluout/writedata/pc), stamps each store
// with a 1-based cycle number and streams the records out over valid/ready.
module store_trace_recorder
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int CYCW  = TRACE_CYCW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memwrite,
    input  logic [31:0]     aluout,
    input  logic [31:0]     writedata,
    input  logic [31:0]     pc,
    input  logic [31:0]     pc_finished,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic [CYCW-1:0] rec_cycle,
    output logic [31:0]     rec_addr,
    output logic [31:0]     rec_data,
    output logic [15:0]     dropped,
    output logic            finished,
    output logic            done
);

    logic [CYCW-1:0] cyc;
    logic            at_end;
    logic            capture;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    trace_rec_t      new_rec;
    trace_rec_t      head_rec;

    // A store issued in the end cycle itself is never recorded.
    assign at_end  = (pc == pc_finished);
    assign capture = memwrite & ~at_end & ~finished;
    assign pop     = rec_valid & rec_ready;
    assign push    = capture & (~full | pop);

    // The stamp is the 1-based number of the current cycle.
    always_comb begin
        new_rec       = '0;
        new_rec.cycle = TRACE_CYCW'(cyc + 1'b1);
        new_rec.addr  = aluout;
        new_rec.data  = writedata;
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wr_rec (new_rec),
        .rd_rec (head_rec),
        .full   (full),
        .empty  (empty)
    );

    assign rec_valid = ~empty;
    assign rec_cycle = CYCW'(head_rec.cycle);
    assign rec_addr  = head_rec.addr;
    assign rec_data  = head_rec.data;
    assign done      = finished & empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc      <= '0;
            finished <= 1'b0;
            dropped  <= '0;
        end else begin
            if (~finished & ~at_end) cyc <= cyc + 1'b1;
            if (at_end)              finished <= 1'b1;
            // Overflow loses the record; the counter sticks at its maximum.
            if (capture & full & ~pop & (dropped != 16'hFFFF))
                dropped <= dropped + 16'd1;
        end
    end

endmodule

// File: tb/tb_store_trace_recorder.sv
// Directed bench for store_trace_recorder: a reference queue of expected
// records is filled as stores are driven and drained as the DUT emits them.
module tb_store_trace_recorder;
    import trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CYCW  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            memwrite;
    logic [31:0]     aluout;
    logic [31:0]     writedata;
    logic [31:0]     pc;
    logic [31:0]     pc_finished;
    logic            rec_valid;
    logic            rec_ready;
    logic [CYCW-1:0] rec_cycle;
    logic [31:0]     rec_addr;
    logic [31:0]     rec_data;
    logic [15:0]     dropped;
    logic            finished;
    logic            done;

    int checks = 0;
    int errors = 0;

    trace_rec_t  exp_q[$];
    logic [31:0] m_cyc;
    logic [15:0] m_dropped;
    logic        m_finished;

    always #5 clk = ~clk;

    store_trace_recorder #(
        .DEPTH (DEPTH),
        .CYCW  (CYCW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .aluout      (aluout),
        .writedata   (writedata),
        .pc          (pc),
        .pc_finished (pc_finished),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_cycle   (rec_cycle),
        .rec_addr    (rec_addr),
        .rec_data    (rec_data),
        .dropped     (dropped),
        .finished    (finished),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reset held for one cycle; the cycle following release is cycle 1.
    task automatic do_reset();
        reset    = 1'b1;
        memwrite = 1'b0;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        exp_q.delete();
        m_cyc      = '0;
        m_dropped  = '0;
        m_finished = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, then
    // advance the model and the clock together.
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic rdy, input logic [31:0] pc_v);
        logic       m_pop;
        logic       m_full;
        logic       m_at_end;
        trace_rec_t rec;
        memwrite  = we;
        aluout    = addr;
        writedata = data;
        rec_ready = rdy;
        pc        = pc_v;
        #1;
        check("rec_valid", 64'(rec_valid), 64'(exp_q.size() != 0));
        check("dropped",   64'(dropped),   64'(m_dropped));
        check("finished",  64'(finished),  64'(m_finished));
        check("done",      64'(done),      64'(m_finished && exp_q.size() == 0));
        if (exp_q.size() != 0) begin
            check("rec_cycle", 64'(rec_cycle), 64'(exp_q[0].cycle));
            check("rec_addr",  64'(rec_addr),  64'(exp_q[0].addr));
            check("rec_data",  64'(rec_data),  64'(exp_q[0].data));
        end
        m_full   = (exp_q.size() == DEPTH);
        m_pop    = rdy && (exp_q.size() != 0);
        m_at_end = (pc_v == pc_finished);
        if (m_pop) void'(exp_q.pop_front());
        if (we && !m_at_end && !m_finished) begin
            if (!m_full || m_pop) begin
                rec.cycle = m_cyc + 32'd1;
                rec.addr  = addr;
                rec.data  = data;
                exp_q.push_back(rec);
            end else if (m_dropped != 16'hFFFF) begin
                m_dropped++;
            end
        end
        if (!m_finished && !m_at_end) m_cyc++;
        if (m_at_end) m_finished = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        memwrite    = 1'b0;
        aluout      = '0;
        writedata   = '0;
        pc          = 32'h0;
        pc_finished = PC_NO_END;
        rec_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single store in cycle 3, popped in cycle 4, empty in cycle 5.
        step(1'b0, 32'h0,  32'h0, 1'b1, 32'h0);
        step(1'b0, 32'h0,  32'h0, 1'b1, 32'h4);
        step(1'b1, 32'h54, 32'h7, 1'b1, 32'h8);
        check("single_cycle_stamp", 64'(rec_cycle), 64'd3);
        step(1'b0, 32'h0,  32'h0, 1'b1, 32'hC);
        step(1'b0, 32'h0,  32'h0, 1'b1, 32'h10);

        // Backpressure: 18 stores into a 16-deep FIFO drop two.
        for (int i = 0; i < 18; i++)
            step(1'b1, 32'h100 + 32'(4 * i), 32'(i), 1'b0, 32'h14);
        check("overflow_dropped", 64'(dropped), 64'd2);
        // Full with a simultaneous pop: lossless, new record goes to the tail.
        step(1'b1, 32'h200, 32'd100, 1'b1, 32'h18);
        check("full_pop_dropped", 64'(dropped), 64'd2);
        // Still full afterwards, so a store without a pop is dropped.
        step(1'b1, 32'h204, 32'd101, 1'b0, 32'h1C);
        check("still_full_dropped", 64'(dropped), 64'd3);
        for (int i = 0; i < DEPTH + 2; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);

        // Reset mid-drain flushes queued records; next store stamps cycle 1.
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 32'h24);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h28);
        do_reset();
        check("reset_rec_valid", 64'(rec_valid), 64'd0);
        check("reset_dropped",   64'(dropped),   64'd0);
        check("reset_finished",  64'(finished),  64'd0);
        step(1'b1, 32'h400, 32'h55, 1'b1, 32'h0);
        check("post_reset_stamp", 64'(rec_cycle), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h4);

        // End of program: store at the end PC suppressed, then drain to done.
        pc_finished = 32'h3C;
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h500 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 32'h30 + 32'(4 * i));
        step(1'b1, 32'h600, 32'hDEAD, 1'b0, 32'h3C);
        check("end_finished", 64'(finished), 64'd1);
        step(1'b1, 32'h604, 32'hBEEF, 1'b0, 32'h3C);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 32'h3C);
        check("end_done", 64'(done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
